// File: rtl/trap_pkg.sv
// Shared types and constants for the trap sequencer: FSM states, mcause codes,
// mstatus field positions and the decoded-event record from the priority encoder.
package trap_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP     = 2'd1,
        RET      = 2'd2,
        REDIRECT = 2'd3
    } state_e;

    localparam int CAUSE_W = 4;

    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL    = 4'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_BREAKPOINT = 4'd3;
    localparam logic [CAUSE_W-1:0] CAUSE_ECALL_M    = 4'd11;

    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    typedef struct packed {
        logic               evt;
        logic               is_ret;
        logic [CAUSE_W-1:0] cause;
    } prio_t;

endpackage

// File: rtl/trap_cause_prio.sv
// Priority encoder from retiring-instruction flags to a single trap/return event.
// Exceptions always win over mret; illegal > ebreak > ecall.
module trap_cause_prio
    import trap_pkg::*;
(
    input  logic  inst_valid_i,
    input  logic  is_ecall_i,
    input  logic  is_ebreak_i,
    input  logic  is_illegal_i,
    input  logic  is_mret_i,
    output prio_t prio_o
);

    always_comb begin
        prio_o = '0;
        if (inst_valid_i) begin
            if (is_illegal_i) begin
                prio_o.evt   = 1'b1;
                prio_o.cause = CAUSE_ILLEGAL;
            end else if (is_ebreak_i) begin
                prio_o.evt   = 1'b1;
                prio_o.cause = CAUSE_BREAKPOINT;
            end else if (is_ecall_i) begin
                prio_o.evt   = 1'b1;
                prio_o.cause = CAUSE_ECALL_M;
            end else if (is_mret_i) begin
                prio_o.evt    = 1'b1;
                prio_o.is_ret = 1'b1;
            end
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: turns retiring exceptions/mret into a CSR trap-entry or mstatus
// restore, then hands the new PC to fetch over a valid/ready redirect.
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_valid,
    input  logic                  is_ecall,
    input  logic                  is_ebreak,
    input  logic                  is_illegal,
    input  logic                  is_mret,
    input  logic [DATA_WIDTH-1:0] pc,
    input  logic [DATA_WIDTH-1:0] mtvec,
    input  logic [DATA_WIDTH-1:0] mepc,
    input  logic [DATA_WIDTH-1:0] mstatus,
    output logic                  intr,
    output logic [DATA_WIDTH-1:0] intr_NO,
    output logic [DATA_WIDTH-1:0] intr_epc,
    output logic                  mret_wen,
    output logic [DATA_WIDTH-1:0] mstatus_new,
    output logic                  csr_wen_kill,
    output logic                  stall,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    input  logic                  redirect_ready
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] epc_q, epc_d;
    logic [CAUSE_W-1:0]    cause_q, cause_d;
    logic [DATA_WIDTH-1:0] tgt_q, tgt_d;
    logic [DATA_WIDTH-1:0] mstatus_ret;
    prio_t                 prio;

    // Targets are word aligned; mode bits of mtvec and low bits of mepc are dropped.
    logic unused_low_bits;
    assign unused_low_bits = ^{mtvec[1:0], mepc[1:0]};

    trap_cause_prio u_prio (
        .inst_valid_i (inst_valid),
        .is_ecall_i   (is_ecall),
        .is_ebreak_i  (is_ebreak),
        .is_illegal_i (is_illegal),
        .is_mret_i    (is_mret),
        .prio_o       (prio)
    );

    always_comb begin
        mstatus_ret                                = mstatus;
        mstatus_ret[MSTATUS_MIE]                   = mstatus[MSTATUS_MPIE];
        mstatus_ret[MSTATUS_MPIE]                  = 1'b1;
        mstatus_ret[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            epc_q   <= '0;
            cause_q <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            tgt_q   <= tgt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        epc_d          = epc_q;
        cause_d        = cause_q;
        tgt_d          = tgt_q;
        intr           = 1'b0;
        intr_NO        = '0;
        intr_epc       = '0;
        mret_wen       = 1'b0;
        mstatus_new    = '0;
        csr_wen_kill   = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        unique case (state_q)
            IDLE: begin
                if (prio.evt) begin
                    // The CSR file favours a normal write over intr, so the
                    // faulting instruction's own CSR write must be squashed here.
                    stall        = 1'b1;
                    csr_wen_kill = 1'b1;
                    epc_d        = pc;
                    cause_d      = prio.cause;
                    state_d      = prio.is_ret ? RET : TRAP;
                end
            end
            TRAP: begin
                stall    = 1'b1;
                intr     = 1'b1;
                intr_NO  = DATA_WIDTH'(cause_q);
                intr_epc = epc_q;
                tgt_d    = {mtvec[DATA_WIDTH-1:2], 2'b00};
                state_d  = REDIRECT;
            end
            RET: begin
                stall       = 1'b1;
                mret_wen    = 1'b1;
                mstatus_new = mstatus_ret;
                tgt_d       = {mepc[DATA_WIDTH-1:2], 2'b00};
                state_d     = REDIRECT;
            end
            REDIRECT: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = tgt_q;
                if (redirect_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: inputs driven just after posedge, outputs checked at negedge.
module tb_trap_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_valid, is_ecall, is_ebreak, is_illegal, is_mret;
    logic [W-1:0] pc, mtvec, mepc, mstatus;
    logic         intr, mret_wen, csr_wen_kill, stall, redirect_valid, redirect_ready;
    logic [W-1:0] intr_NO, intr_epc, mstatus_new, redirect_pc;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    trap_ctrl #(.DATA_WIDTH(W)) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .is_ecall       (is_ecall),
        .is_ebreak      (is_ebreak),
        .is_illegal     (is_illegal),
        .is_mret        (is_mret),
        .pc             (pc),
        .mtvec          (mtvec),
        .mepc           (mepc),
        .mstatus        (mstatus),
        .intr           (intr),
        .intr_NO        (intr_NO),
        .intr_epc       (intr_epc),
        .mret_wen       (mret_wen),
        .mstatus_new    (mstatus_new),
        .csr_wen_kill   (csr_wen_kill),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".stall"}, W'(stall), 0);
        chk({tag, ".kill"}, W'(csr_wen_kill), 0);
        chk({tag, ".intr"}, W'(intr), 0);
        chk({tag, ".mret_wen"}, W'(mret_wen), 0);
        chk({tag, ".rv"}, W'(redirect_valid), 0);
        chk({tag, ".rpc"}, redirect_pc, 0);
        chk({tag, ".intr_NO"}, intr_NO, 0);
        chk({tag, ".intr_epc"}, intr_epc, 0);
        chk({tag, ".mstatus_new"}, mstatus_new, 0);
    endtask

    task automatic clear_flags();
        inst_valid = 0; is_ecall = 0; is_ebreak = 0; is_illegal = 0; is_mret = 0;
    endtask

    // Event cycle N, TRAP at N+1, REDIRECT at N+2 (ready high), IDLE at N+3.
    task automatic run_trap(input string tag, input logic [3:0] flags, input logic [W-1:0] p,
                            input logic [W-1:0] cause, input logic [W-1:0] tgt);
        tick();
        inst_valid = 1; {is_illegal, is_ebreak, is_ecall, is_mret} = flags; pc = p;
        @(negedge clk);
        chk({tag, ".N.stall"}, W'(stall), 1);
        chk({tag, ".N.kill"}, W'(csr_wen_kill), 1);
        chk({tag, ".N.intr"}, W'(intr), 0);
        tick();
        clear_flags();
        @(negedge clk);
        chk({tag, ".N1.intr"}, W'(intr), 1);
        chk({tag, ".N1.cause"}, intr_NO, cause);
        chk({tag, ".N1.epc"}, intr_epc, p);
        chk({tag, ".N1.mret_wen"}, W'(mret_wen), 0);
        chk({tag, ".N1.kill"}, W'(csr_wen_kill), 0);
        chk({tag, ".N1.stall"}, W'(stall), 1);
        tick();
        @(negedge clk);
        chk({tag, ".N2.rv"}, W'(redirect_valid), 1);
        chk({tag, ".N2.rpc"}, redirect_pc, tgt);
        chk({tag, ".N2.intr"}, W'(intr), 0);
        chk({tag, ".N2.mret_wen"}, W'(mret_wen), 0);
        tick();
        @(negedge clk);
        chk_quiet({tag, ".N3"});
    endtask

    initial begin
        rst = 1; clear_flags();
        pc = '0; mtvec = '0; mepc = '0; mstatus = '0; redirect_ready = 0;
        tick(); tick();
        @(negedge clk);
        chk_quiet("reset");
        tick();
        rst = 0;
        mtvec = 32'h8000_0101; redirect_ready = 1;
        @(negedge clk);
        chk_quiet("post_reset");

        run_trap("ecall", 4'b0010, 32'h8000_0010, 11, 32'h8000_0100);
        run_trap("ill_ecall", 4'b1010, 32'h8000_0020, 2, 32'h8000_0100);
        run_trap("ebrk_mret", 4'b0101, 32'h8000_0030, 3, 32'h8000_0100);

        // mret: restore mstatus, redirect to mepc
        tick();
        mstatus = 32'h0000_0080; mepc = 32'h8000_0014;
        inst_valid = 1; is_mret = 1; pc = 32'h8000_0040;
        @(negedge clk);
        chk("mret.N.stall", W'(stall), 1);
        chk("mret.N.kill", W'(csr_wen_kill), 1);
        tick();
        clear_flags();
        @(negedge clk);
        chk("mret.N1.wen", W'(mret_wen), 1);
        chk("mret.N1.mstatus_new", mstatus_new, 32'h0000_1888);
        chk("mret.N1.intr", W'(intr), 0);
        tick();
        @(negedge clk);
        chk("mret.N2.wen", W'(mret_wen), 0);
        chk("mret.N2.rv", W'(redirect_valid), 1);
        chk("mret.N2.rpc", redirect_pc, 32'h8000_0014);
        tick();
        @(negedge clk);
        chk_quiet("mret.N3");

        // mret with MPIE=0 clears MIE, other bits kept
        tick();
        mstatus = 32'hF000_0008; mepc = 32'h8000_0057;
        inst_valid = 1; is_mret = 1;
        tick();
        clear_flags();
        @(negedge clk);
        chk("mret2.mstatus_new", mstatus_new, 32'hF000_1880);
        tick();
        @(negedge clk);
        chk("mret2.rpc", redirect_pc, 32'h8000_0054);
        tick();

        // Redirect back-pressure; mtvec change must not leak into redirect_pc
        mtvec = 32'h8000_0200; redirect_ready = 0;
        inst_valid = 1; is_ecall = 1; pc = 32'h8000_0060;
        tick();
        clear_flags();
        tick();
        mtvec = 32'h1234_5678;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp.%0d.rv", i), W'(redirect_valid), 1);
            chk($sformatf("bp.%0d.rpc", i), redirect_pc, 32'h8000_0200);
            chk($sformatf("bp.%0d.stall", i), W'(stall), 1);
            tick();
        end
        redirect_ready = 1;
        @(negedge clk);
        chk("bp.hs.rv", W'(redirect_valid), 1);
        chk("bp.hs.rpc", redirect_pc, 32'h8000_0200);
        tick();
        @(negedge clk);
        chk_quiet("bp.idle");

        // Reset during TRAP drops the pending trap
        tick();
        mtvec = 32'h8000_0300;
        inst_valid = 1; is_illegal = 1; pc = 32'h8000_0070;
        tick();
        clear_flags();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_quiet($sformatf("rst_trap.%0d", i));
            tick();
        end

        // Flags without inst_valid are not an event
        inst_valid = 0; is_ecall = 1; is_mret = 1;
        @(negedge clk);
        chk("novalid.stall", W'(stall), 0);
        chk("novalid.kill", W'(csr_wen_kill), 0);
        tick();
        clear_flags();
        @(negedge clk);
        chk_quiet("novalid.next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
